// File: rtl/vproc_xif_pkg.sv
// Shared types for the XIF result receiver: per-ID slot lifecycle states.
package vproc_xif_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_ISSUED    = 2'd1,
        SLOT_COMMITTED = 2'd2,
        SLOT_KILLED    = 2'd3
    } slot_state_e;

    // A result may only target an instruction that is still live and not killed.
    function automatic logic result_target_legal(slot_state_e s);
        return (s == SLOT_ISSUED) || (s == SLOT_COMMITTED);
    endfunction

endpackage

// File: rtl/vproc_xif_result_rx.sv
// Core-side XIF result receiver: allocates IDs, tracks commit/kill per ID and
// accepts coprocessor results strictly in ID order, producing registered write-back.
module vproc_xif_result_rx
    import vproc_xif_pkg::*;
#(
    parameter int XIF_ID_W       = 3,
    parameter bit DONT_CARE_ZERO = 1'b0
) (
    input  logic                clk_i,
    input  logic                async_rst_ni,
    input  logic                sync_rst_ni,

    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    output logic [XIF_ID_W-1:0] issue_id_o,

    input  logic                commit_valid_i,
    input  logic [XIF_ID_W-1:0] commit_id_i,
    input  logic                commit_kill_i,

    input  logic                result_valid_i,
    output logic                result_ready_o,
    input  logic [XIF_ID_W-1:0] result_id_i,
    input  logic [31:0]         result_data_i,
    input  logic [4:0]          result_rd_i,
    input  logic                result_we_i,
    input  logic                result_exc_i,
    input  logic [5:0]          result_exccode_i,

    output logic                wb_valid_o,
    output logic [4:0]          wb_addr_o,
    output logic [31:0]         wb_data_o,

    output logic                exc_valid_o,
    output logic [XIF_ID_W-1:0] exc_id_o,
    output logic [5:0]          exc_code_o,

    output logic [XIF_ID_W:0]   outstanding_o,
    output logic                protocol_err_o
);

    localparam int XIF_ID_CNT = 1 << XIF_ID_W;
    localparam int CNT_W      = XIF_ID_W + 1;

    slot_state_e         slot_q [XIF_ID_CNT];
    slot_state_e         slot_d [XIF_ID_CNT];
    logic [XIF_ID_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [XIF_ID_W-1:0] ret_ptr_q, ret_ptr_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic                protocol_err_q, protocol_err_d;
    logic                wb_valid_q, wb_valid_d;
    logic [4:0]          wb_addr_q, wb_addr_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic                exc_valid_q, exc_valid_d;
    logic [XIF_ID_W-1:0] exc_id_q, exc_id_d;
    logic [5:0]          exc_code_q, exc_code_d;

    logic issue_ready;
    logic issue_fire;
    logic result_accept;
    logic slot_freed;
    logic wb_write;

    // Readiness uses the pre-update state, so a slot freed this cycle is reusable next cycle.
    assign issue_ready = (slot_q[alloc_ptr_q] == SLOT_FREE);
    assign issue_fire  = issue_valid_i & issue_ready;
    assign wb_write    = result_we_i & ~result_exc_i & (result_rd_i != 5'd0);

    always_comb begin
        slot_d         = slot_q;
        alloc_ptr_d    = alloc_ptr_q;
        ret_ptr_d      = ret_ptr_q;
        protocol_err_d = protocol_err_q;
        wb_valid_d     = 1'b0;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        exc_valid_d    = 1'b0;
        exc_id_d       = exc_id_q;
        exc_code_d     = exc_code_q;
        result_accept  = 1'b0;
        slot_freed     = 1'b0;

        if (commit_valid_i) begin
            if (slot_q[commit_id_i] == SLOT_ISSUED) begin
                slot_d[commit_id_i] = commit_kill_i ? SLOT_KILLED : SLOT_COMMITTED;
            end else begin
                protocol_err_d = 1'b1;
            end
        end

        // A same-cycle commit is not yet visible in slot_q, so such a result stalls one cycle.
        if (slot_q[ret_ptr_q] == SLOT_KILLED) begin
            slot_freed = 1'b1;
        end else if (slot_q[ret_ptr_q] == SLOT_COMMITTED && result_valid_i
                     && result_id_i == ret_ptr_q) begin
            result_accept = 1'b1;
            slot_freed    = 1'b1;
        end

        if (slot_freed) begin
            slot_d[ret_ptr_q] = SLOT_FREE;
            ret_ptr_d         = ret_ptr_q + XIF_ID_W'(1);
        end

        if (result_valid_i && (result_id_i != ret_ptr_q
                               || !result_target_legal(slot_q[result_id_i]))) begin
            protocol_err_d = 1'b1;
        end

        if (result_accept) begin
            wb_valid_d  = wb_write;
            exc_valid_d = result_exc_i;
            if (wb_write) begin
                wb_addr_d = result_rd_i;
                wb_data_d = result_data_i;
            end
            if (result_exc_i) begin
                exc_id_d   = ret_ptr_q;
                exc_code_d = result_exccode_i;
            end
        end

        if (issue_fire) begin
            slot_d[alloc_ptr_q] = SLOT_ISSUED;
            alloc_ptr_d         = alloc_ptr_q + XIF_ID_W'(1);
        end

        outstanding_d = outstanding_q + CNT_W'(issue_fire) - CNT_W'(slot_freed);

        if (!sync_rst_ni) begin
            for (int i = 0; i < XIF_ID_CNT; i++) begin
                slot_d[i] = SLOT_FREE;
            end
            alloc_ptr_d    = '0;
            ret_ptr_d      = '0;
            outstanding_d  = '0;
            protocol_err_d = 1'b0;
            wb_valid_d     = 1'b0;
            exc_valid_d    = 1'b0;
            wb_addr_d      = DONT_CARE_ZERO ? '0 : 'x;
            wb_data_d      = DONT_CARE_ZERO ? '0 : 'x;
            exc_id_d       = DONT_CARE_ZERO ? '0 : 'x;
            exc_code_d     = DONT_CARE_ZERO ? '0 : 'x;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            for (int i = 0; i < XIF_ID_CNT; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
            alloc_ptr_q    <= '0;
            ret_ptr_q      <= '0;
            outstanding_q  <= '0;
            protocol_err_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            exc_valid_q    <= 1'b0;
            wb_addr_q      <= DONT_CARE_ZERO ? '0 : 'x;
            wb_data_q      <= DONT_CARE_ZERO ? '0 : 'x;
            exc_id_q       <= DONT_CARE_ZERO ? '0 : 'x;
            exc_code_q     <= DONT_CARE_ZERO ? '0 : 'x;
        end else begin
            for (int i = 0; i < XIF_ID_CNT; i++) begin
                slot_q[i] <= slot_d[i];
            end
            alloc_ptr_q    <= alloc_ptr_d;
            ret_ptr_q      <= ret_ptr_d;
            outstanding_q  <= outstanding_d;
            protocol_err_q <= protocol_err_d;
            wb_valid_q     <= wb_valid_d;
            exc_valid_q    <= exc_valid_d;
            wb_addr_q      <= wb_addr_d;
            wb_data_q      <= wb_data_d;
            exc_id_q       <= exc_id_d;
            exc_code_q     <= exc_code_d;
        end
    end

    assign issue_ready_o  = issue_ready;
    assign issue_id_o     = alloc_ptr_q;
    assign result_ready_o = result_accept;
    assign wb_valid_o     = wb_valid_q;
    assign wb_addr_o      = wb_addr_q;
    assign wb_data_o      = wb_data_q;
    assign exc_valid_o    = exc_valid_q;
    assign exc_id_o       = exc_id_q;
    assign exc_code_o     = exc_code_q;
    assign outstanding_o  = outstanding_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_vproc_xif_result_rx.sv
// Directed, table-driven bench for vproc_xif_result_rx plus reset corner sequences.
module tb_vproc_xif_result_rx;

    logic        clk_i = 1'b0;
    logic        async_rst_ni, sync_rst_ni;
    logic        issue_valid_i, issue_ready_o;
    logic [2:0]  issue_id_o;
    logic        commit_valid_i, commit_kill_i;
    logic [2:0]  commit_id_i;
    logic        result_valid_i, result_ready_o;
    logic [2:0]  result_id_i;
    logic [31:0] result_data_i;
    logic [4:0]  result_rd_i;
    logic        result_we_i, result_exc_i;
    logic [5:0]  result_exccode_i;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        exc_valid_o;
    logic [2:0]  exc_id_o;
    logic [5:0]  exc_code_o;
    logic [3:0]  outstanding_o;
    logic        protocol_err_o;

    always #5 clk_i = ~clk_i;

    vproc_xif_result_rx #(.XIF_ID_W(3), .DONT_CARE_ZERO(1'b1)) dut (
        .clk_i(clk_i), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_o(issue_id_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o), .result_id_i(result_id_i),
        .result_data_i(result_data_i), .result_rd_i(result_rd_i), .result_we_i(result_we_i),
        .result_exc_i(result_exc_i), .result_exccode_i(result_exccode_i),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .exc_valid_o(exc_valid_o), .exc_id_o(exc_id_o), .exc_code_o(exc_code_o),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    // Inputs, then expected pre-edge combinational outputs, then expected post-edge registers.
    typedef struct {
        logic iv; logic cv; logic [2:0] cid; logic ck;
        logic rv; logic [2:0] rid; logic [31:0] data; logic [4:0] rd; logic we; logic exc; logic [5:0] code;
        logic e_ir; logic [2:0] e_iid; logic e_rr;
        logic e_wbv; logic [4:0] e_wba; logic [31:0] e_wbd;
        logic e_excv; logic [2:0] e_exid; logic [5:0] e_exc; logic [3:0] e_out; logic e_err;
    } vec_t;

    vec_t vecs [34];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid_i = 0; commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
        result_valid_i = 0; result_id_i = 0; result_data_i = 0; result_rd_i = 0;
        result_we_i = 0; result_exc_i = 0; result_exccode_i = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " issue_ready"}, 32'(issue_ready_o), 32'd1);
        chk({tag, " issue_id"}, 32'(issue_id_o), 32'd0);
        chk({tag, " wb_valid"}, 32'(wb_valid_o), 32'd0);
        chk({tag, " wb_addr"}, 32'(wb_addr_o), 32'd0);
        chk({tag, " wb_data"}, wb_data_o, 32'd0);
        chk({tag, " exc_valid"}, 32'(exc_valid_o), 32'd0);
        chk({tag, " exc_id"}, 32'(exc_id_o), 32'd0);
        chk({tag, " exc_code"}, 32'(exc_code_o), 32'd0);
        chk({tag, " outstanding"}, 32'(outstanding_o), 32'd0);
        chk({tag, " protocol_err"}, 32'(protocol_err_o), 32'd0);
    endtask

    initial begin
        //           iv cv cid ck rv rid data          rd we ex code  ir iid rr wbv wba wbd          exv exid exc   out err
        // Three in-order results with write-back
        vecs[0]  = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,0,0, 0,0,32'h0,   0,0,6'h0, 1,0};
        vecs[1]  = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,1,0, 0,0,32'h0,   0,0,6'h0, 2,0};
        vecs[2]  = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,2,0, 0,0,32'h0,   0,0,6'h0, 3,0};
        vecs[3]  = '{0,1,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,3,0, 0,0,32'h0,   0,0,6'h0, 3,0};
        vecs[4]  = '{0,1,1,0, 0,0,32'h0,   0,0,0,6'h0,  1,3,0, 0,0,32'h0,   0,0,6'h0, 3,0};
        vecs[5]  = '{0,1,2,0, 0,0,32'h0,   0,0,0,6'h0,  1,3,0, 0,0,32'h0,   0,0,6'h0, 3,0};
        vecs[6]  = '{0,0,0,0, 1,0,32'hA,   5,1,0,6'h0,  1,3,1, 1,5,32'hA,   0,0,6'h0, 2,0};
        vecs[7]  = '{0,0,0,0, 1,1,32'hB,   6,1,0,6'h0,  1,3,1, 1,6,32'hB,   0,0,6'h0, 1,0};
        vecs[8]  = '{0,0,0,0, 1,2,32'hC,   7,1,0,6'h0,  1,3,1, 1,7,32'hC,   0,0,6'h0, 0,0};
        vecs[9]  = '{0,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,3,0, 0,7,32'hC,   0,0,6'h0, 0,0};
        // Kill ID 3, commit ID 4: killed slot retires in one cycle, no write-back for it
        vecs[10] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,3,0, 0,7,32'hC,   0,0,6'h0, 1,0};
        vecs[11] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,4,0, 0,7,32'hC,   0,0,6'h0, 2,0};
        vecs[12] = '{0,1,3,1, 0,0,32'h0,   0,0,0,6'h0,  1,5,0, 0,7,32'hC,   0,0,6'h0, 2,0};
        vecs[13] = '{0,1,4,0, 0,0,32'h0,   0,0,0,6'h0,  1,5,0, 0,7,32'hC,   0,0,6'h0, 1,0};
        vecs[14] = '{0,0,0,0, 1,4,32'h44,  9,1,0,6'h0,  1,5,1, 1,9,32'h44,  0,0,6'h0, 0,0};
        // Exception result: no write-back, single-cycle exception pulse
        vecs[15] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,5,0, 0,9,32'h44,  0,0,6'h0, 1,0};
        vecs[16] = '{0,1,5,0, 0,0,32'h0,   0,0,0,6'h0,  1,6,0, 0,9,32'h44,  0,0,6'h0, 1,0};
        vecs[17] = '{0,0,0,0, 1,5,32'h55,  3,1,1,6'h0D, 1,6,1, 0,9,32'h44,  1,5,6'h0D, 0,0};
        vecs[18] = '{0,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,6,0, 0,9,32'h44,  0,5,6'h0D, 0,0};
        // Fill all eight IDs (pointer wraps 7 -> 0)
        vecs[19] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,6,0, 0,9,32'h44,  0,5,6'h0D, 1,0};
        vecs[20] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,7,0, 0,9,32'h44,  0,5,6'h0D, 2,0};
        vecs[21] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,0,0, 0,9,32'h44,  0,5,6'h0D, 3,0};
        vecs[22] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,1,0, 0,9,32'h44,  0,5,6'h0D, 4,0};
        vecs[23] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,2,0, 0,9,32'h44,  0,5,6'h0D, 5,0};
        vecs[24] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,3,0, 0,9,32'h44,  0,5,6'h0D, 6,0};
        vecs[25] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,4,0, 0,9,32'h44,  0,5,6'h0D, 7,0};
        vecs[26] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,5,0, 0,9,32'h44,  0,5,6'h0D, 8,0};
        vecs[27] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  0,6,0, 0,9,32'h44,  0,5,6'h0D, 8,0};
        // Retire ID 6 (rd=0 suppresses write-back), then the freed ID is reissued
        vecs[28] = '{0,1,6,0, 0,0,32'h0,   0,0,0,6'h0,  0,6,0, 0,9,32'h44,  0,5,6'h0D, 8,0};
        vecs[29] = '{0,0,0,0, 1,6,32'h66,  0,1,0,6'h0,  0,6,1, 0,9,32'h44,  0,5,6'h0D, 7,0};
        vecs[30] = '{1,0,0,0, 0,0,32'h0,   0,0,0,6'h0,  1,6,0, 0,9,32'h44,  0,5,6'h0D, 8,0};
        // Out-of-order result flags an error; same-cycle commit+result stalls one cycle
        vecs[31] = '{0,0,0,0, 1,0,32'h11,  1,1,0,6'h0,  0,7,0, 0,9,32'h44,  0,5,6'h0D, 8,1};
        vecs[32] = '{0,1,7,0, 1,7,32'h77,  4,1,0,6'h0,  0,7,0, 0,9,32'h44,  0,5,6'h0D, 8,1};
        vecs[33] = '{0,0,0,0, 1,7,32'h77,  4,1,0,6'h0,  0,7,1, 1,4,32'h77,  0,5,6'h0D, 7,1};

        idle_inputs();
        async_rst_ni = 0;
        sync_rst_ni  = 1;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("por");
        async_rst_ni = 1;

        for (int i = 0; i < 34; i++) begin
            @(negedge clk_i);
            issue_valid_i = vecs[i].iv; commit_valid_i = vecs[i].cv;
            commit_id_i = vecs[i].cid; commit_kill_i = vecs[i].ck;
            result_valid_i = vecs[i].rv; result_id_i = vecs[i].rid;
            result_data_i = vecs[i].data; result_rd_i = vecs[i].rd;
            result_we_i = vecs[i].we; result_exc_i = vecs[i].exc;
            result_exccode_i = vecs[i].code;
            #1;
            chk($sformatf("v%0d issue_ready", i), 32'(issue_ready_o), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d issue_id", i), 32'(issue_id_o), 32'(vecs[i].e_iid));
            chk($sformatf("v%0d result_ready", i), 32'(result_ready_o), 32'(vecs[i].e_rr));
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid_o), 32'(vecs[i].e_wbv));
            chk($sformatf("v%0d wb_addr", i), 32'(wb_addr_o), 32'(vecs[i].e_wba));
            chk($sformatf("v%0d wb_data", i), wb_data_o, vecs[i].e_wbd);
            chk($sformatf("v%0d exc_valid", i), 32'(exc_valid_o), 32'(vecs[i].e_excv));
            chk($sformatf("v%0d exc_id", i), 32'(exc_id_o), 32'(vecs[i].e_exid));
            chk($sformatf("v%0d exc_code", i), 32'(exc_code_o), 32'(vecs[i].e_exc));
            chk($sformatf("v%0d outstanding", i), 32'(outstanding_o), 32'(vecs[i].e_out));
            chk($sformatf("v%0d protocol_err", i), 32'(protocol_err_o), 32'(vecs[i].e_err));
            $display("[TB] vector %0d applied: ready=%0b id=%0d out=%0d", i,
                     result_ready_o, issue_id_o, outstanding_o);
        end

        // Async reset mid-cycle with 7 outstanding and a write-back just registered
        @(negedge clk_i);
        idle_inputs();
        async_rst_ni = 0;
        #1;
        check_reset_outputs("async_rst");
        $display("[TB] async reset applied with work outstanding");
        async_rst_ni = 1;

        // First result after reset targets a FREE slot
        @(negedge clk_i);
        result_valid_i = 1; result_id_i = 0; result_we_i = 1; result_rd_i = 3; result_data_i = 32'h99;
        #1;
        chk("post_rst result_ready", 32'(result_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("post_rst protocol_err", 32'(protocol_err_o), 32'd1);
        chk("post_rst wb_valid", 32'(wb_valid_o), 32'd0);
        $display("[TB] stray result after reset: err=%0b", protocol_err_o);

        // Synchronous reset clears the sticky error; commit to a FREE slot sets it again
        @(negedge clk_i);
        idle_inputs();
        issue_valid_i = 1;
        sync_rst_ni = 0;
        @(posedge clk_i);
        #1;
        chk("sync_rst protocol_err", 32'(protocol_err_o), 32'd0);
        chk("sync_rst outstanding", 32'(outstanding_o), 32'd0);
        chk("sync_rst issue_id", 32'(issue_id_o), 32'd0);
        $display("[TB] sync reset applied: err=%0b out=%0d", protocol_err_o, outstanding_o);
        @(negedge clk_i);
        sync_rst_ni = 1;
        issue_valid_i = 0;
        commit_valid_i = 1; commit_id_i = 2;
        @(posedge clk_i);
        #1;
        chk("bad_commit protocol_err", 32'(protocol_err_o), 32'd1);
        chk("bad_commit outstanding", 32'(outstanding_o), 32'd0);
        $display("[TB] commit to free slot: err=%0b", protocol_err_o);
        @(negedge clk_i);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vproc_xif_result_rx.md
Name: vproc_xif_result_rx

Overview:
Core-side receiver for the coprocessor result channel of the eXtension interface (XIF).
- Allocates instruction IDs at issue and tracks each ID through commit or kill.
- Accepts coprocessor results strictly in ID order.
- Turns accepted results into a registered register-file write or exception report for the scalar pipeline.
- Sits between the scalar core's offload/commit logic and the coprocessor's result arbiter.

Parameters:
XIF_ID_W, 3, width of instruction IDs; XIF_ID_CNT = 1<<XIF_ID_W slots
DONT_CARE_ZERO, 1'b0, drive don't-care outputs to zero instead of 'x

Ports:
clk_i  in  1  clock
async_rst_ni  in  1  asynchronous reset, active-low
sync_rst_ni  in  1  synchronous reset, active-low
issue_valid_i  in  1  core offloads an instruction
issue_ready_o  out  1  a free ID is available
issue_id_o  out  XIF_ID_W  ID assigned to the offloaded instruction (= alloc_ptr)
commit_valid_i  in  1  commit/kill decision valid
commit_id_i  in  XIF_ID_W  ID being committed or killed
commit_kill_i  in  1  1 = kill, 0 = commit
result_valid_i  in  1  coprocessor result valid
result_ready_o  out  1  result accepted this cycle
result_id_i  in  XIF_ID_W  result instruction ID
result_data_i  in  32  write-back data
result_rd_i  in  5  destination register
result_we_i  in  1  write-back enable
result_exc_i  in  1  exception flag
result_exccode_i  in  6  exception code
wb_valid_o  out  1  register-file write, registered
wb_addr_o  out  5  write address
wb_data_o  out  32  write data
exc_valid_o  out  1  exception report, registered, single-cycle pulse
exc_id_o  out  XIF_ID_W  ID of the faulting instruction
exc_code_o  out  6  exception code
outstanding_o  out  XIF_ID_W+1  number of non-FREE slots
protocol_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async or sync):
  - all slots FREE; alloc_ptr = ret_ptr = 0;
  - wb_valid_o = exc_valid_o = protocol_err_o = 0; outstanding_o = 0; issue_ready_o = 1;
  - wb_addr_o/wb_data_o/exc_code_o/exc_id_o: 0 if DONT_CARE_ZERO, else 'x.
- Slot states (slot_state_e): FREE, ISSUED, COMMITTED, KILLED.
- Issue:
  - issue_ready_o = (slot[alloc_ptr] == FREE).
  - On issue_valid_i & issue_ready_o: slot[alloc_ptr] <= ISSUED; alloc_ptr increments modulo XIF_ID_CNT.
  - Full condition: all XIF_ID_CNT slots non-FREE, giving issue_ready_o = 0.
- Commit:
  - On commit_valid_i with slot[commit_id_i] == ISSUED: state becomes KILLED if commit_kill_i, else COMMITTED.
  - Commit to a slot in any other state: state is unchanged and protocol_err_o is set.
- Retire (ret_ptr = next expected result ID):
  - slot[ret_ptr] == KILLED: slot <= FREE, ret_ptr++. One killed slot per cycle; no result is expected for it.
  - slot[ret_ptr] == COMMITTED and result_valid_i & result_id_i == ret_ptr: result_ready_o = 1 (combinational); slot <= FREE; ret_ptr++.
  - Any other case: result_ready_o = 0.
- Protocol errors on results:
  - result_valid_i with result_id_i != ret_ptr, or targeting a FREE/KILLED slot, sets protocol_err_o.
  - The result is stalled, never dropped.
  - protocol_err_o is cleared only by reset.
- Result timing:
  - A result for a slot still ISSUED (commit not yet seen) stalls.
  - Commit and result for the same ID in the same cycle: the commit is taken, result_ready_o = 0, and the result is accepted in the next cycle at the earliest.
- Write-back (1-cycle latency after acceptance):
  - wb_valid_o = result_we_i & ~result_exc_i & (result_rd_i != 0).
  - If wb_valid_o: wb_addr_o/wb_data_o are the registered rd/data; otherwise they hold their previous values.
- Exceptions: exc_valid_o = result_exc_i, with exc_id_o = accepted ID and exc_code_o = result_exccode_i, all registered.
- Simultaneous events:
  - Issue, commit and retire in one cycle are all legal.
  - They target different slots, except issue into a slot freed this same cycle: not allowed, because issue_ready_o uses the pre-update state.
- Wrap-around: both pointers wrap modulo XIF_ID_CNT; ordering is determined solely by ret_ptr.
- outstanding_o: registered count of non-FREE slots, updated each cycle (+issue, -free).
- Reset mid-operation: every slot is abandoned and no write-back or exception fires in the following cycle.

Decomposition:
- vproc_xif_pkg: slot_state_e (2-bit enum).
- No sub-module; the slot array and both pointers are inline.

Test Plan:
- Issue IDs 0,1,2; commit all three; results arrive for 0,1,2 with we=1, rd=5/6/7, data 0xA/0xB/0xC -> one wb_valid_o pulse per cycle, each 1 cycle after its result_ready_o.
- Issue 0,1; kill 0; commit 1; result for 1 -> ret_ptr skips 0 in one cycle, then result 1 is accepted; no wb for ID 0.
- Fill all 8 IDs -> issue_ready_o = 0 and outstanding_o = 8; retire ID 0 -> issue_ready_o = 1 next cycle; next issue gets ID 0 (wrap-around).
- Result with exc=1, exccode=0x0D, we=1 -> exc_valid_o pulses with code 0x0D, wb_valid_o stays 0.
- Result for ID 1 while ret_ptr = 0 -> result_ready_o = 0, protocol_err_o = 1; same-cycle commit+result for ID 0 -> accepted one cycle later.
- Assert async_rst_ni with 3 outstanding -> all outputs at reset values; a result arriving the next cycle raises protocol_err_o.
